// File: rtl/sdram_arbit_pkg.sv
// Shared state encodings and pin fill values for the SDRAM command arbiter.
package sdram_arbit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ARBIT = 3'b001,
    ST_CHAN  = 3'b010,
    ST_AREF  = 3'b011
  } state_e;

  localparam int unsigned CMD_W    = 4;
  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;
  localparam logic        FILL_BIT = 1'b1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Round-robin / fixed-priority pick: first set request at or after ptr, wrapping to index 0.
module sdram_rr_pick
  import sdram_arbit_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_en,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Two masked scans give the same result as rotating req by ptr and priority-encoding.
  always_comb begin
    int unsigned base;
    valid = 1'b0;
    idx   = '0;
    base  = rr_en ? 32'(ptr) : 32'd0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= base)) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: init / auto-refresh / NUM_CH client channels onto the SDRAM pins.
module sdram_arbit_rr
  import sdram_arbit_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  parameter  int unsigned DQ_W   = 16,
  parameter  int unsigned ADDR_W = 13,
  parameter  int unsigned BA_W   = 2,
  parameter  bit          RR_EN  = 1'b1,
  localparam int unsigned GI_W   = idx_w(NUM_CH)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CMD_W-1:0]         init_cmd,
  input  logic [BA_W-1:0]          init_ba,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic                     init_end,
  input  logic                     aref_req,
  input  logic [CMD_W-1:0]         aref_cmd,
  input  logic [BA_W-1:0]          aref_ba,
  input  logic [ADDR_W-1:0]        aref_addr,
  input  logic                     aref_end,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [CMD_W*NUM_CH-1:0]  ch_cmd,
  input  logic [BA_W*NUM_CH-1:0]   ch_ba,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DQ_W*NUM_CH-1:0]   ch_wdata,
  input  logic [NUM_CH-1:0]        ch_dq_oe,
  input  logic [NUM_CH-1:0]        ch_end,
  output logic                     aref_en,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [GI_W-1:0]          grant_idx,
  output logic                     sdram_cke,
  output logic                     sdram_cs_n,
  output logic                     sdram_ras_n,
  output logic                     sdram_cas_n,
  output logic                     sdram_we_n,
  output logic [BA_W-1:0]          sdram_ba,
  output logic [ADDR_W-1:0]        sdram_addr,
  inout  wire  [DQ_W-1:0]          sdram_dq
);

  state_e              state_q;
  logic                aref_en_q;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [GI_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GI_W-1:0]     grant_idx_q;
  logic                pick_valid;
  logic [GI_W-1:0]     pick_idx;

  logic [CMD_W-1:0]    c_cmd   [NUM_CH];
  logic [BA_W-1:0]     c_ba    [NUM_CH];
  logic [ADDR_W-1:0]   c_addr  [NUM_CH];
  logic [DQ_W-1:0]     c_wdata [NUM_CH];

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_unpack
    assign c_cmd[g]   = ch_cmd[g*CMD_W +: CMD_W];
    assign c_ba[g]    = ch_ba[g*BA_W +: BA_W];
    assign c_addr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign c_wdata[g] = ch_wdata[g*DQ_W +: DQ_W];
  end

  sdram_rr_pick #(.N(NUM_CH)) u_pick (
    .req   (ch_req),
    .ptr   (rr_ptr_q),
    .rr_en (RR_EN),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rr_ptr_d = (32'(pick_idx) + 32'd1 == NUM_CH) ? '0 : pick_idx + GI_W'(1);

  // Grant FSM; every grant returns through ARBIT so grants are never back-to-back.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      aref_en_q   <= 1'b0;
      ch_en_q     <= '0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (init_end) state_q <= ST_ARBIT;
        ST_ARBIT: begin
          if (aref_req) begin
            state_q   <= ST_AREF;
            aref_en_q <= 1'b1;
          end else if (pick_valid) begin
            state_q     <= ST_CHAN;
            ch_en_q     <= NUM_CH'(1) << pick_idx;
            grant_idx_q <= pick_idx;
            if (RR_EN) rr_ptr_q <= rr_ptr_d;
          end
        end
        ST_AREF: begin
          if (aref_end) begin
            state_q   <= ST_ARBIT;
            aref_en_q <= 1'b0;
          end
        end
        ST_CHAN: begin
          if (ch_end[grant_idx_q]) begin
            state_q <= ST_ARBIT;
            ch_en_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          aref_en_q <= 1'b0;
          ch_en_q   <= '0;
        end
      endcase
    end
  end

  // Pin mux follows the state register directly; reset forces the init source.
  logic [CMD_W-1:0]  sel_cmd;
  logic [BA_W-1:0]   sel_ba;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_cmd  = CMD_NOP;
    sel_ba   = {BA_W{FILL_BIT}};
    sel_addr = {ADDR_W{FILL_BIT}};
    if (!sys_rst_n || state_q == ST_IDLE) begin
      sel_cmd  = init_cmd;
      sel_ba   = init_ba;
      sel_addr = init_addr;
    end else if (state_q == ST_AREF) begin
      sel_cmd  = aref_cmd;
      sel_ba   = aref_ba;
      sel_addr = aref_addr;
    end else if (state_q == ST_CHAN) begin
      sel_cmd  = c_cmd[grant_idx_q];
      sel_ba   = c_ba[grant_idx_q];
      sel_addr = c_addr[grant_idx_q];
    end
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;
  assign sdram_ba   = sel_ba;
  assign sdram_addr = sel_addr;
  assign sdram_dq   = (state_q == ST_CHAN && ch_dq_oe[grant_idx_q]) ? c_wdata[grant_idx_q]
                                                                     : {DQ_W{1'bz}};

  assign aref_en   = aref_en_q;
  assign ch_en     = ch_en_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: doc/sdram_arbit_rr.md
# sdram_arbit_rr

Parametrised SDRAM command arbiter between the init, auto-refresh and control layers. It serves `NUM_CH` generic read/write client channels instead of one fixed write port and one fixed read port. Auto-refresh always has priority over the channels. Among the channels, the grant is round-robin (or fixed-priority via parameter). The selected source's command, bank and address are multiplexed onto the SDRAM pins, and the bidirectional DQ bus is driven from the granted channel.

## Interface
- `NUM_CH`, 2: client channels (1..8).
- `DQ_W`, 16: SDRAM data width.
- `ADDR_W`, 13: SDRAM address width.
- `BA_W`, 2: bank address width.
- `RR_EN`, 1: 1 = round-robin among channels; 0 = fixed priority, lowest index wins.
- `sys_clk`  in  1  single clock, 100 MHz.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `init_cmd` / `init_ba` / `init_addr` / `init_end`  in  4 / BA_W / ADDR_W / 1  init layer command; `init_end` pulses once when init is done.
- `aref_req` / `aref_cmd` / `aref_ba` / `aref_addr` / `aref_end`  in  1 / 4 / BA_W / ADDR_W / 1  refresh layer.
- `ch_req`  in  NUM_CH  per-channel request level.
- `ch_cmd`  in  4*NUM_CH  packed; channel k occupies bits [4k+3:4k].
- `ch_ba` / `ch_addr` / `ch_wdata`  in  BA_W*NUM_CH / ADDR_W*NUM_CH / DQ_W*NUM_CH  packed, same scheme.
- `ch_dq_oe`  in  NUM_CH  channel wants DQ driven.
- `ch_end`  in  NUM_CH  channel transaction-done pulse.
- `aref_en`  out  1  refresh grant, registered.
- `ch_en`  out  NUM_CH  one-hot channel grant, registered.
- `grant_idx`  out  $clog2(NUM_CH) (min 1)  index of the last channel granted.
- `sdram_cke` / `sdram_cs_n` / `sdram_ras_n` / `sdram_cas_n` / `sdram_we_n`  out  1 each  `cke` is constant 1; `{cs_n, ras_n, cas_n, we_n}` = the muxed command.
- `sdram_ba` / `sdram_addr`  out  BA_W / ADDR_W  muxed bank and address.
- `sdram_dq`  inout  DQ_W  data bus.

## Operation
- States: IDLE, ARBIT, AREF, CHAN.
- Reset values: state = IDLE, `aref_en` = 0, `ch_en` = 0, `rr_ptr` = 0, `grant_idx` = 0.
- IDLE → ARBIT when `init_end` = 1.
- ARBIT:
  - `aref_req` = 1 → AREF and `aref_en` ← 1. This wins even if `ch_req` ≠ 0.
  - Otherwise `ch_req` ≠ 0 → CHAN, with `ch_en` ← onehot(w) and `grant_idx` ← w.
  - Otherwise stay in ARBIT.
- Winner w:
  - `RR_EN` = 1: first k with `ch_req[k]` set, scanning `rr_ptr`, `rr_ptr`+1, … modulo NUM_CH.
  - `RR_EN` = 0: lowest set index.
- `rr_ptr` ← (w+1) mod NUM_CH on each channel grant, only when `RR_EN` = 1.
- AREF → ARBIT on `aref_end`; `aref_en` ← 0 on the same edge.
- CHAN → ARBIT on `ch_end[grant_idx]`; `ch_en` ← 0 on the same edge. `ch_end` from non-granted channels is ignored.
- Pin mux (combinational from state):
  - IDLE or reset asserted: init source.
  - ARBIT: NOP (0111), `ba` all ones, `addr` all ones.
  - AREF: aref source.
  - CHAN: source channel `grant_idx`.
  - Illegal state: NOP and all ones on `ba`/`addr`, with the state register returning to IDLE.
- DQ is driven with `ch_wdata[grant_idx]` only while state = CHAN and `ch_dq_oe[grant_idx]` = 1. Otherwise DQ is high-Z.

## Timing
- Grant latency: request sampled in ARBIT → state, `*_en` and pin mux all change on the next edge, i.e. 1 cycle.
- Each completed transaction is followed by at least one ARBIT cycle, during which the pins carry NOP.
- Simultaneous `*_end` and a new `aref_req`/`ch_req`: go to ARBIT first; arbitration happens the following cycle. No back-to-back grants.
- `aref_req` raised during CHAN waits; it is taken at the next ARBIT. The block performs no preemption.
- With `RR_EN` = 1 and all NUM_CH channels requesting continuously, each channel is granted exactly once per NUM_CH channel grants.
- Reset asserted mid-transaction: all outputs immediately take their reset values and the pins follow the init source. After release, no grant is issued until `init_end`.

## Structure
- Package `sdram_arbit_pkg`:
  - state encodings (IDLE = 000, ARBIT = 001, AREF = 011, CHAN = 010);
  - NOP = 4'b0111;
  - idle `ba`/`addr` fill value (all ones).
- Sub-module `sdram_rr_pick`: combinational rotate-and-priority-encode over NUM_CH bits.
  - Inputs: `req`, `ptr`, `rr_en`.
  - Outputs: `valid`, `idx`.

## Test plan
1. Reset, then `init_end` pulse with NUM_CH = 2 → pins show `init_cmd` while in IDLE; NOP 0111, `ba` = 3, `addr` = 0x1FFF one cycle after `init_end`.
2. In ARBIT, `aref_req` = 1 together with `ch_req` = 2'b11 → `aref_en` = 1 and `ch_en` = 0; after `aref_end`, one ARBIT cycle, then `ch_en` = 2'b01.
3. `RR_EN` = 1, NUM_CH = 4, `ch_req` = 4'b1111 held, `ch_end` pulsed 3 cycles after each grant → grant order 0, 1, 2, 3, 0. With `RR_EN` = 0 the order is 0, 0, 0.
4. Channel 1 granted with `ch_dq_oe[1]` = 1 and `ch_wdata[1]` = 0xA5A5 → `sdram_dq` = 0xA5A5. `ch_dq_oe[0]` = 1 has no effect; `sdram_dq` is Z in ARBIT.
5. `ch_end[0]` pulsed while channel 1 is granted → stays in CHAN. Reset asserted mid-CHAN → `ch_en` = 0, state IDLE, and pins carry `init_cmd` within the same cycle.
